div_sequencer: RTL and testbench
================================

// Module: div_sequencer
// PURPOSE
//  Multi-cycle sequencer for the HI/LO divide resource. Accepts a DIV/DIVU
//  issued from execute and runs a radix-2 restoring divide over WIDTH
//  iterations. Delivers the remainder on div_hi and the quotient on div_lo,
//  with a one-cycle done pulse; writeback carries these as has_div_w,
//  div_hi_w and div_lo_w. Raises stall_d to the hazard unit while a divide
//  is outstanding and decode holds MFHI/MFLO or another divide.
// PARAMETERS
//  WIDTH  32  operand, quotient and remainder width; iteration count
// PORTS
//  clock       in   1      system clock; every register updates on posedge
//  reset       in   1      synchronous, active-high
//  start       in   1      divide issued this cycle (has_div in execute)
//  is_signed   in   1      1 = DIV, 0 = DIVU; sampled with start
//  dividend    in   WIDTH  rs value; sampled with start
//  divisor     in   WIDTH  rt value; sampled with start
//  mf_op_in_d  in   1      MFHI/MFLO currently in decode
//  has_div_d   in   1      divide currently in decode
//  busy        out  1      divide in progress (RUN state)
//  stall_d     out  1      stall request to hazard unit (combinational)
//  done        out  1      one-cycle pulse; div_hi/div_lo valid
//  div_hi      out  WIDTH  remainder (registered)
//  div_lo      out  WIDTH  quotient (registered)
// BEHAVIOUR
//  Reset: state=IDLE, count=0; busy, done, div_hi, div_lo all 0.
//  Reset mid-divide aborts the divide: no done pulse, outputs return to 0.
//  States:
//  - IDLE: start=1 latches |dividend|, |divisor| (abs only if is_signed),
//    both sign bits and is_signed; count=0 -> RUN.
//  - RUN: one restoring step per cycle; count+1. After step WIDTH-1 -> FIN.
//  - FIN: sign-fixup. On the edge leaving FIN: div_hi/div_lo load and done=1
//    for exactly one cycle. Then -> IDLE, or -> RUN if start=1 in FIN
//    (back-to-back; the new operands are latched).
//  Latency: start sampled at edge N -> done high in cycle after edge N+WIDTH+2,
//    i.e. WIDTH+2 clocks. div_hi/div_lo hold their value until the next done.
//  busy = (state==RUN) | (state==FIN).
//  stall_d = (busy | start) & (mf_op_in_d | has_div_d).
//  start during RUN is a protocol violation: ignored. The bench asserts
//    that it never occurs.
//  Signed results: quotient negated iff sign(dividend) != sign(divisor);
//    remainder takes the sign of the dividend. Magnitude math uses WIDTH+1
//    bits, so -2^(WIDTH-1) is handled.
//  Divide by zero (same latency, no exception): div_lo = all ones;
//    div_hi = original dividend. Applies to both signed and unsigned.
//  Signed overflow, 0x80000000 / -1: div_lo = 0x80000000, div_hi = 0.
//  done and the new div_hi/div_lo rise on the same edge; writeback consumes
//    them in that cycle.
// STRUCTURE
//  Shared package (div_defs.vh):
//  - DIV_IDLE/DIV_RUN/DIV_FIN state encodings (2 bits)
//  - DIV_WIDTH default
//  - DIV_ZERO_QUOT constant (all ones)
//  Sub-module div_step: combinational single restoring iteration.
//  - inputs: partial remainder, quotient shift register, divisor
//  - outputs: next remainder and next quotient
//  Sequencer keeps FSM, counter, operand/sign registers and output registers.
// TESTING
//  1 DIVU 100/7, start 1 cycle -> done exactly 34 clocks later;
//    lo=14, hi=2; busy low after done.
//  2 DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF;
//    DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
//  3 DIVU 5/0 -> lo=0xFFFFFFFF, hi=5;
//    DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//  4 mf_op_in_d=1 from start cycle through done -> stall_d=1 every cycle
//    until done; stall_d=0 in the done cycle and with mf_op_in_d=0.
//  5 reset asserted at RUN count=10 -> next cycle busy=0, div_hi=div_lo=0;
//    no done pulse within the following 40 cycles.
//  6 back-to-back: start held in FIN for DIVU 9/4 after 100/7 -> done(14,2),
//    then done(2,1) exactly 34 clocks later.

Source files
------------

// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the HI/LO divide sequencer.
package div_sequencer_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_RUN  = 2'b01,
    DIV_FIN  = 2'b10
  } div_state_e;

  // Quotient reported for a divide by zero.
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring divide iteration on magnitudes.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Shift in the next dividend bit and keep the trial subtraction if it fits.
  // The partial remainder is always below the divisor, so the low WIDTH bits
  // of the difference are exact whenever the subtraction is kept.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    ge      = (shifted >= {1'b0, dvs_i});
    diff    = shifted[WIDTH-1:0] - dvs_i;
    if (ge) begin
      rem_o = diff;
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU sequencer feeding the HI/LO registers.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             mf_op_in_d,
  input  logic             has_div_d,
  output logic             busy,
  output logic             stall_d,
  output logic             done,
  output logic [WIDTH-1:0] div_hi,
  output logic [WIDTH-1:0] div_lo
);

  localparam int unsigned    CW        = $clog2(WIDTH + 2);
  localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  FIX_CNT   = CW'(WIDTH);
  localparam logic [CW-1:0]  PUB_CNT   = CW'(WIDTH + 1);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic [WIDTH-1:0] fix_hi_q, fix_hi_d;
  logic [WIDTH-1:0] fix_lo_q, fix_lo_d;
  logic [WIDTH-1:0] div_hi_q, div_hi_d;
  logic [WIDTH-1:0] div_lo_q, div_lo_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_rem, step_quo;
  logic             publish;
  logic             accept;
  logic             sa, sb;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  assign publish = (state_q == DIV_FIN) && (count_q == PUB_CNT);
  assign accept  = start && ((state_q == DIV_IDLE) || publish);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: IDLE -> RUN on start, RUN -> FIN after the last step,
  // FIN -> RUN/IDLE once the result is published.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE: if (start)                  state_d = DIV_RUN;
      DIV_RUN:  if (count_q == LAST_STEP)   state_d = DIV_FIN;
      DIV_FIN:  if (count_q == PUB_CNT)     state_d = start ? DIV_RUN : DIV_IDLE;
      default:                              state_d = DIV_IDLE;
    endcase
  end

  // FSM-derived outputs and the hazard-unit stall request.
  always_comb begin
    busy    = (state_q == DIV_RUN) || (state_q == DIV_FIN);
    stall_d = (busy || start) && (mf_op_in_d || has_div_d);
  end

  // Datapath: operand capture, iteration, sign fix-up and result publication.
  // FIN spans two cycles: the fix-up is registered first, then published,
  // which places done WIDTH+2 clocks after the sampling edge.
  always_comb begin
    count_d  = count_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    fix_hi_d = fix_hi_q;
    fix_lo_d = fix_lo_q;
    div_hi_d = div_hi_q;
    div_lo_d = div_lo_q;
    done_d   = 1'b0;
    sa       = is_signed && dividend[WIDTH-1];
    sb       = is_signed && divisor[WIDTH-1];

    unique case (state_q)
      DIV_RUN: begin
        rem_d   = step_rem;
        quo_d   = step_quo;
        count_d = count_q + CW'(1);
      end
      DIV_FIN: begin
        count_d = count_q + CW'(1);
        if (count_q == FIX_CNT) begin
          // A zero divisor leaves the dividend magnitude as remainder, so
          // the usual remainder sign rule restores the original dividend.
          fix_hi_d = neg_a_q ? -rem_q : rem_q;
          if (dvs_q == '0) begin
            fix_lo_d = {WIDTH{DIV_ZERO_QUOT[0]}};
          end else begin
            fix_lo_d = (neg_a_q ^ neg_b_q) ? -quo_q : quo_q;
          end
        end
        if (publish) begin
          div_hi_d = fix_hi_q;
          div_lo_d = fix_lo_q;
          done_d   = 1'b1;
        end
      end
      default: ;
    endcase

    if (accept) begin
      neg_a_d = sa;
      neg_b_d = sb;
      quo_d   = sa ? -dividend : dividend;
      dvs_d   = sb ? -divisor : divisor;
      rem_d   = '0;
      count_d = '0;
    end
  end

  // Datapath registers; reset aborts any divide and clears the results.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      fix_hi_q <= '0;
      fix_lo_q <= '0;
      div_hi_q <= '0;
      div_lo_q <= '0;
      done_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      fix_hi_q <= fix_hi_d;
      fix_lo_q <= fix_lo_d;
      div_hi_q <= div_hi_d;
      div_lo_q <= div_lo_d;
      done_q   <= done_d;
    end
  end

  assign done   = done_q;
  assign div_hi = div_hi_q;
  assign div_lo = div_lo_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: edge-counting behavioural model
// plus directed literal checks and randomized traffic.
module tb_div_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        mf_op_in_d;
  logic        has_div_d;
  logic        busy;
  logic        stall_d;
  logic        done;
  logic [31:0] div_hi;
  logic [31:0] div_lo;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  div_sequencer #(.WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .mf_op_in_d (mf_op_in_d),
    .has_div_d  (has_div_d),
    .busy       (busy),
    .stall_d    (stall_d),
    .done       (done),
    .div_hi     (div_hi),
    .div_lo     (div_lo)
  );

  // Model state: edge counter, in-flight job, and expected registered outputs.
  int          cyc = 0;
  bit          job_active = 1'b0;
  int          job_n = 0;
  logic [31:0] job_hi, job_lo;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_done = 1'b0;
  logic        m_busy = 1'b0;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, q, r;
    if (b == 32'd0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    cyc++;
    if (reset) begin
      job_active = 1'b0;
      m_hi   = '0;
      m_lo   = '0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (job_active && cyc == job_n + 34) begin
        m_done = 1'b1;
        m_hi   = job_hi;
        m_lo   = job_lo;
        job_active = 1'b0;
      end
      assert (!(start && job_active)) else $error("protocol: start while divide in progress");
      if (start && !job_active) begin
        job_active = 1'b1;
        job_n = cyc;
        ref_div(is_signed, dividend, divisor, job_hi, job_lo);
      end
    end
    m_busy = job_active;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic step_rand();
    mf_op_in_d = 1'($urandom_range(0, 1));
    has_div_d  = 1'($urandom_range(0, 1));
    step();
  endtask

  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    step();
    start = 1'b0; dividend = $urandom; divisor = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      step();
      lat++;
    end while (done !== 1'b1 && lat < 60);
  endtask

  task automatic do_div(input string name, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    logic [31:0] h, l;
    int lat;
    ref_div(s, a, b, h, l);
    chk({name, "_model_hi"}, h, eh);
    chk({name, "_model_lo"}, l, el);
    issue(s, a, b);
    wait_done(lat);
    chk({name, "_latency"}, 32'(lat), 32'd34);
    chk({name, "_lo"}, div_lo, el);
    chk({name, "_hi"}, div_hi, eh);
    chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
    step();
    chk({name, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("done", 32'(done), 32'(m_done));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("stall_d", 32'(stall_d), 32'((m_busy | start) & (mf_op_in_d | has_div_d)));
      chk("div_hi", div_hi, m_hi);
      chk("div_lo", div_lo, m_lo);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: run exceeded time limit, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int  lat;
    bit  seen;
    bit  b2b;

    start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    mf_op_in_d = 1'b0; has_div_d = 1'b0; reset = 1'b1;
    repeat (3) step();
    chk_en = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", div_hi, 32'd0);
    chk("rst_lo", div_lo, 32'd0);
    reset = 1'b0;
    step();

    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14);
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    do_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    do_div("div_m9_0", 1'b1, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF);

    // Stall held while MFHI/MFLO waits in decode.
    mf_op_in_d = 1'b1;
    start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
    #1;
    chk("stall_start", 32'(stall_d), 32'd1);
    step();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      chk("stall_run", 32'(stall_d), 32'd1);
      step();
      lat++;
    end
    chk("stall_latency", 32'(lat), 32'd34);
    chk("stall_done", 32'(stall_d), 32'd0);
    chk("stall_q", div_lo, 32'd333);
    mf_op_in_d = 1'b0;
    #1;
    chk("stall_idle", 32'(stall_d), 32'd0);
    step();

    // Reset partway through RUN aborts the divide.
    issue(1'b1, 32'hFFFF_FC18, 32'd7);
    repeat (10) step();
    reset = 1'b1;
    step();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", div_hi, 32'd0);
    chk("abort_lo", div_lo, 32'd0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      step();
      if (done === 1'b1) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);

    // Back-to-back: second divide latched on the edge that publishes the first.
    issue(1'b0, 32'd100, 32'd7);
    repeat (33) step();
    start = 1'b1; is_signed = 1'b0; dividend = 32'd9; divisor = 32'd4;
    step();
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    chk("b2b_done1", 32'(done), 32'd1);
    chk("b2b_lo1", div_lo, 32'd14);
    chk("b2b_hi1", div_hi, 32'd2);
    wait_done(lat);
    chk("b2b_latency", 32'(lat), 32'd34);
    chk("b2b_lo2", div_lo, 32'd2);
    chk("b2b_hi2", div_hi, 32'd1);
    step();

    // Randomized traffic with random decode hazards and back-to-back issues.
    b2b = 1'b0;
    for (int k = 0; k < 150; k++) begin
      if (!b2b) repeat ($urandom_range(0, 3)) step_rand();
      start = 1'b1;
      is_signed = 1'($urandom_range(0, 1));
      dividend = rnd_op();
      divisor = rnd_op();
      step_rand();
      start = 1'b0; dividend = $urandom; divisor = $urandom;
      repeat (33) step_rand();
      b2b = 1'($urandom_range(0, 1));
      if (!b2b) step_rand();
    end
    repeat (4) step_rand();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
